pipe_stage_elastic: RTL and testbench

//   Parametrised, elastic pipeline register that replaces the per-stage hand-coded registers (IF/ID .. MEM/WB).

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_sat_counter.sv | 26 ++
 rtl/pipe_stage_elastic.sv | 113 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types, widths and helpers for elastic pipeline stages.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pipe_pkg;

    localparam int PIPE_MAX_DEPTH = 8;
    localparam int PIPE_CNT_W     = 4;
    localparam int PIPE_PTR_W     = 3;

    // MEM/WB control field layout, shared by the stages that build in_ctrl
    localparam int MEMWB_REGWRITE_BIT = 0;
    localparam int MEMWB_MEMTOREG_BIT = 1;
    localparam int MEMWB_MEMREAD_BIT  = 2;
    localparam int MEMWB_MEMWRITE_BIT = 3;
    localparam int MEMWB_CTRL_W       = 4;

    typedef struct packed {
        logic mem_write;
        logic mem_read;
        logic memto_reg;
        logic reg_write;
    } memwb_ctrl_t;

    // Advance a buffer pointer, wrapping DEPTH-1 -> 0 so non-power-of-two depths work
    function automatic logic [PIPE_PTR_W-1:0] ptr_inc(input logic [PIPE_PTR_W-1:0] ptr,
                                                      input logic [PIPE_CNT_W-1:0] depth);
        logic [PIPE_PTR_W-1:0] nxt;
        if (PIPE_CNT_W'(ptr) == depth - 1'b1) begin
            nxt = '0;
        end else begin
            nxt = ptr + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter; holds at all-ones, cleared only by reset.
// Latency: count reflects an enabled cycle one clock later.
// Backpressure: none; en is sampled every cycle.
module pipe_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    // Count enabled cycles, stopping at the maximum value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a DEPTH-entry FIFO buffer; PIPE_STAGE_PERF_EN adds stall/bubble counters.
// Latency: 1 cycle from push to out_*; full throughput including push+pop at full.
// Backpressure: in_ready drops only when full and out_ready is low; out_ready->in_ready is combinational.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 69,
    parameter int DEPTH  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_CNT_W-1:0] count
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           bubble_cycles
`endif
);

    localparam logic [PIPE_CNT_W-1:0] DEPTH_C = PIPE_CNT_W'(DEPTH);

    // Arrays are sized to the maximum depth so the pointers index them exactly;
    // slots at or above DEPTH are never written and stay zero.
    logic [CTRL_W-1:0]     r_ctrl [PIPE_MAX_DEPTH];
    logic [DATA_W-1:0]     r_data [PIPE_MAX_DEPTH];
    logic [PIPE_PTR_W-1:0] r_wr_ptr;
    logic [PIPE_PTR_W-1:0] r_rd_ptr;
    logic [PIPE_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign out_valid = (r_count != '0);
    assign in_ready  = (r_count < DEPTH_C) || ((r_count == DEPTH_C) && out_ready);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    // Control is masked to a NOP when no entry is present; data is left visible for debug
    assign out_ctrl  = out_valid ? r_ctrl[r_rd_ptr] : '0;
    assign out_data  = r_data[r_rd_ptr];
    assign count     = r_count;

    // Pointer and occupancy update; flush resets bookkeeping but leaves storage intact
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr, DEPTH_C);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr, DEPTH_C);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage: written at the tail on every accepted push
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_MAX_DEPTH; i++) begin
                r_ctrl[i] <= '0;
                r_data[i] <= '0;
            end
        end else if (w_push) begin
            r_ctrl[r_wr_ptr] <= in_ctrl;
            r_data[r_wr_ptr] <= in_data;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic w_stall;
    logic w_bubble;

    assign w_stall  = out_valid && !out_ready;
    assign w_bubble = !out_valid && out_ready;

    pipe_sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .en    (w_stall),
        .cnt   (stall_cycles)
    );

    pipe_sat_counter #(.WIDTH(32)) u_bubble_cnt (
        .clock (clock),
        .reset (reset),
        .en    (w_bubble),
        .cnt   (bubble_cycles)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a DEPTH=2 and a DEPTH=3 instance share one stimulus stream.
// Each instance is compared every cycle with a push/pop-count reference model.
// Directed scenarios first, then a randomized phase.
module tb_pipe_stage_elastic;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_ctrl = '0;
    logic [68:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        rdy2, vld2, rdy3, vld3;
    logic [3:0]  ctl2, ctl3, cnt2, cnt3;
    logic [68:0] dat2, dat3;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall2, bubble2, stall3, bubble3;
`endif

    always #5 clock = ~clock;

    pipe_stage_elastic #(.CTRL_W(4), .DATA_W(69), .DEPTH(2)) u_dut2 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy2), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(vld2), .out_ready(out_ready), .out_ctrl(ctl2), .out_data(dat2),
        .count(cnt2)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cycles(stall2), .bubble_cycles(bubble2)
`endif
    );

    pipe_stage_elastic #(.CTRL_W(4), .DATA_W(69), .DEPTH(3)) u_dut3 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy3), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(vld3), .out_ready(out_ready), .out_ctrl(ctl3), .out_data(dat3),
        .count(cnt3)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cycles(stall3), .bubble_cycles(bubble3)
`endif
    );

    // Reference model: the n-th push since reset/flush lands in slot n % DEPTH,
    // the head is the slot of the next pop; occupancy is pushes minus pops.
    logic [68:0] m_data [2][8];
    logic [3:0]  m_ctrl [2][8];
    int          n_push [2];
    int          n_pop  [2];
    int          m_stall [2];
    int          m_bubble [2];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic int dep(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            n_push[k] = 0;
            n_pop[k] = 0;
            m_stall[k] = 0;
            m_bubble[k] = 0;
            for (int s = 0; s < 8; s++) begin
                m_data[k][s] = '0;
                m_ctrl[k][s] = '0;
            end
        end
    endtask

    task automatic check_dut(input int k, input logic rdy, input logic v, input logic [3:0] c,
                             input logic [68:0] d, input logic [3:0] cnt);
        int   depth;
        int   occ;
        int   head;
        logic erdy;
        depth = dep(k);
        occ   = n_push[k] - n_pop[k];
        head  = n_pop[k] % depth;
        erdy  = (occ < depth) || ((occ == depth) && out_ready);
        chk($sformatf("d%0d_in_ready", depth), 69'(rdy), 69'(erdy));
        chk($sformatf("d%0d_out_valid", depth), 69'(v), 69'(occ != 0));
        chk($sformatf("d%0d_out_ctrl", depth), 69'(c), (occ != 0) ? 69'(m_ctrl[k][head]) : 69'(0));
        chk($sformatf("d%0d_out_data", depth), d, m_data[k][head]);
        chk($sformatf("d%0d_count", depth), 69'(cnt), 69'(occ));
    endtask

    task automatic check_all();
        check_dut(0, rdy2, vld2, ctl2, dat2, cnt2);
        check_dut(1, rdy3, vld3, ctl3, dat3, cnt3);
    endtask

    task automatic check_perf();
`ifdef PIPE_STAGE_PERF_EN
        chk("d2_stall_cycles", 69'(stall2), 69'(m_stall[0]));
        chk("d2_bubble_cycles", 69'(bubble2), 69'(m_bubble[0]));
        chk("d3_stall_cycles", 69'(stall3), 69'(m_stall[1]));
        chk("d3_bubble_cycles", 69'(bubble3), 69'(m_bubble[1]));
`endif
    endtask

    // Apply the edge just taken to the model, using the inputs that were sampled there
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int   depth;
            int   occ;
            logic rdy;
            logic push;
            logic pop;
            depth = dep(k);
            occ   = n_push[k] - n_pop[k];
            rdy   = (occ < depth) || ((occ == depth) && out_ready);
            push  = in_valid && rdy && !flush;
            pop   = (occ != 0) && out_ready && !flush;
            if ((occ != 0) && !out_ready) m_stall[k]++;
            if ((occ == 0) && out_ready) m_bubble[k]++;
            if (flush) begin
                n_push[k] = 0;
                n_pop[k] = 0;
            end else begin
                if (push) begin
                    m_data[k][n_push[k] % depth] = in_data;
                    m_ctrl[k][n_push[k] % depth] = in_ctrl;
                    n_push[k]++;
                end
                if (pop) n_pop[k]++;
            end
        end
    endtask

    task automatic step(input logic iv, input logic [3:0] ic, input logic [68:0] id,
                        input logic ordy, input logic fl);
        @(negedge clock);
        reset     = 1'b0;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_all();
        @(posedge clock);
        model_edge();
    endtask

    // Assert reset between edges and check the outputs react without waiting for a clock
    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        chk("rst_d2_out_valid", 69'(vld2), 69'(0));
        chk("rst_d2_out_ctrl", 69'(ctl2), 69'(0));
        chk("rst_d2_out_data", dat2, 69'(0));
        chk("rst_d2_count", 69'(cnt2), 69'(0));
        chk("rst_d2_in_ready", 69'(rdy2), 69'(1));
        chk("rst_d3_out_valid", 69'(vld3), 69'(0));
        chk("rst_d3_count", 69'(cnt3), 69'(0));
        chk("rst_d3_in_ready", 69'(rdy3), 69'(1));
        model_clear();
        check_perf();
        @(posedge clock);
    endtask

    function automatic logic [68:0] rand_data();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[68:0];
    endfunction

    initial begin
        model_clear();
        do_reset();

        // Streaming with a ready consumer: each entry shows one cycle after its push
        step(1'b1, 4'h1, 69'hA, 1'b1, 1'b0);
        step(1'b1, 4'h2, 69'hB, 1'b1, 1'b0);
        step(1'b1, 4'h3, 69'hC, 1'b1, 1'b0);
        step(1'b0, 4'h0, 69'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 69'h0, 1'b1, 1'b0);

        // Downstream stall while pushing 1,2,3, then release
        step(1'b1, 4'h5, 69'h1, 1'b0, 1'b0);
        step(1'b1, 4'h6, 69'h2, 1'b0, 1'b0);
        step(1'b1, 4'h7, 69'h3, 1'b0, 1'b0);
        step(1'b1, 4'h7, 69'h3, 1'b0, 1'b0);
        step(1'b1, 4'h7, 69'h3, 1'b1, 1'b0);
        step(1'b0, 4'h0, 69'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 69'h0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 69'h0, 1'b1, 1'b0);

        // Fill, then push and pop together while full
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 1), 69'(16 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'(i + 8), 69'(32 + i), 1'b1, 1'b0);

        // Flush with entries buffered and a push offered in the same cycle
        step(1'b1, 4'hF, 69'h1DEAD, 1'b0, 1'b1);
        step(1'b0, 4'h0, 69'h0, 1'b0, 1'b0);
        step(1'b1, 4'h9, 69'h77, 1'b0, 1'b1);
        step(1'b0, 4'h0, 69'h0, 1'b1, 1'b0);

        // Reset in the middle of a stream with two entries held
        step(1'b1, 4'h1, 69'h41, 1'b0, 1'b0);
        step(1'b1, 4'h2, 69'h42, 1'b0, 1'b0);
        do_reset();

        // Back-to-back pairs long enough to wrap both pointers several times
        for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 69'(100 + i), 1'b1, 1'b0);

        // Randomized traffic: first mostly-stalled, then mostly-flowing
        for (int i = 0; i < 800; i++) begin
            logic ordy;
            ordy = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3) != 0, 4'($urandom), rand_data(), ordy,
                 $urandom_range(0, 24) == 0);
        end

        @(negedge clock);
        check_perf();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
